// File: rtl/ifft_twiddle_sequencer.sv
// Sequences one 32-point radix-2 IFFT frame: twiddle ROM addressing, butterfly operand addresses,
// valid/ready presentation and inter-stage drain gaps. Optional stall counter: TWSEQ_STALL_CNT_EN.
module ifft_twiddle_sequencer #(
    parameter int LOG2N     = 5,
    parameter int DATA_W    = 16,
    parameter int STAGE_GAP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [LOG2N-1:0]  rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              tw_valid,
    input  logic              tw_ready,
    output logic [DATA_W-1:0] tw_data,
    output logic [2:0]        bf_stage,
    output logic [LOG2N-2:0]  bf_idx,
    output logic [LOG2N-1:0]  addr_top,
    output logic [LOG2N-1:0]  addr_bot,
    output logic              stage_last,
`ifdef TWSEQ_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              frame_last
);

    localparam logic [LOG2N-2:0] LASTB   = '1;
    localparam logic [2:0]       LASTS   = 3'(LOG2N - 1);
    localparam logic [15:0]      GAP_RLD = 16'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
    state_t state;

    logic [2:0]       ns;          // next item to issue: stage
    logic [LOG2N-2:0] nb;          // next item to issue: butterfly
    logic             stage_done;  // every butterfly of the current stage has been issued
    logic [15:0]      gap_cnt;

    function automatic logic [LOG2N-1:0] tw_rom(input logic [2:0] s, input logic [LOG2N-2:0] b);
        logic [LOG2N-1:0] m;
        m = (LOG2N'(1) << s) - LOG2N'(1);
        return m + ({1'b0, b} & m);
    endfunction

    function automatic logic [LOG2N-1:0] top_of(input logic [2:0] s, input logic [LOG2N-2:0] b);
        logic [LOG2N-1:0] m, g;
        m = (LOG2N'(1) << s) - LOG2N'(1);
        g = {1'b0, b} >> s;
        return (g << (s + 3'd1)) | ({1'b0, b} & m);
    endfunction

    logic hs, gap_last, chain, advance;
    assign hs       = tw_valid && tw_ready;
    assign gap_last = (state == GAP) && (gap_cnt == 16'd0);
    // Zero gap: the last handshake of a stage issues bf 0 of the next stage in the same cycle.
    assign chain    = (STAGE_GAP == 0) && hs && stage_last && !frame_last;
    assign advance  = ((state == IDLE) && start) || gap_last ||
                      ((state == RUN) && ((!stage_done && (!tw_valid || tw_ready)) || chain));

    // The ROM re-reads the held item during stalls, keeping rom_data aligned with the descriptor.
    assign rom_addr   = advance ? tw_rom(ns, nb) : tw_rom(bf_stage, bf_idx);
    assign tw_data    = rom_data;
    assign stage_last = tw_valid && (bf_idx == LASTB);
    assign frame_last = stage_last && (bf_stage == LASTS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            tw_valid   <= 1'b0;
            bf_stage   <= '0;
            bf_idx     <= '0;
            addr_top   <= '0;
            addr_bot   <= '0;
            ns         <= '0;
            nb         <= '0;
            stage_done <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (advance) begin
                tw_valid <= 1'b1;
                bf_stage <= ns;
                bf_idx   <= nb;
                addr_top <= top_of(ns, nb);
                addr_bot <= top_of(ns, nb) + (LOG2N'(1) << ns);
                if (nb == LASTB) begin
                    ns         <= ns + 3'd1;
                    nb         <= '0;
                    stage_done <= 1'b1;
                end else begin
                    nb         <= nb + 1'b1;
                    stage_done <= 1'b0;
                end
            end else if (hs && stage_done) begin
                tw_valid <= 1'b0;
            end

            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (hs && stage_last) begin
                    if (frame_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        ns    <= '0;
                        nb    <= '0;
                    end else if (STAGE_GAP != 0) begin
                        state   <= GAP;
                        gap_cnt <= GAP_RLD;
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'd0) state <= RUN;
                    else                  gap_cnt <= gap_cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TWSEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if ((state == IDLE) && start)
            stall_cnt <= '0;
        else if (tw_valid && !tw_ready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ifft_twiddle_sequencer.sv
// Directed bench: a STAGE_GAP=4 and a STAGE_GAP=0 sequencer share stimulus, each fed by a ROM model.
module tb_ifft_twiddle_sequencer;

    logic clk = 1'b0;
    logic rst, start, tw_ready;
    always #5 clk = ~clk;

    logic        busy4, done4, v4, sl4, fl4;
    logic [4:0]  ra4, top4, bot4;
    logic [15:0] rd4, tw4;
    logic [2:0]  st4;
    logic [3:0]  ix4;
    logic        busy0, done0, v0, sl0, fl0;
    logic [4:0]  ra0, top0, bot0;
    logic [15:0] rd0, tw0;
    logic [2:0]  st0;
    logic [3:0]  ix0;
`ifdef TWSEQ_STALL_CNT_EN
    logic [15:0] sc4, sc0;
`endif

    ifft_twiddle_sequencer #(.LOG2N(5), .DATA_W(16), .STAGE_GAP(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .busy(busy4), .done(done4), .rom_addr(ra4),
        .rom_data(rd4), .tw_valid(v4), .tw_ready(tw_ready), .tw_data(tw4), .bf_stage(st4),
        .bf_idx(ix4), .addr_top(top4), .addr_bot(bot4), .stage_last(sl4),
`ifdef TWSEQ_STALL_CNT_EN
        .stall_cnt(sc4),
`endif
        .frame_last(fl4));

    ifft_twiddle_sequencer #(.LOG2N(5), .DATA_W(16), .STAGE_GAP(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0), .rom_addr(ra0),
        .rom_data(rd0), .tw_valid(v0), .tw_ready(tw_ready), .tw_data(tw0), .bf_stage(st0),
        .bf_idx(ix0), .addr_top(top0), .addr_bot(bot0), .stage_last(sl0),
`ifdef TWSEQ_STALL_CNT_EN
        .stall_cnt(sc0),
`endif
        .frame_last(fl0));

    // ROM word = {A5, 000, addr}: ROM[0]=A500, ROM[13]=A50D, ROM[14]=A50E.
    always_ff @(posedge clk) begin
        rd4 <= {8'hA5, 3'b000, ra4};
        rd0 <= {8'hA5, 3'b000, ra0};
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int hs4, hs0, busyn, v0n, d4at, d0at, dcnt;

    initial begin
        rst = 1'b1; start = 1'b0; tw_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_busy",  busy4, 0);
        chk("rst_done",  done4, 0);
        chk("rst_valid", v4, 0);
        chk("rst_addr",  ra4, 0);
        chk("rst_stage", st4, 0);
        chk("rst_top",   top4, 0);
        chk("rst_bot",   bot4, 0);
        chk("rst_last",  {sl4, fl4}, 0);

        // Frame 1: ready held high, a stray start at t+30
        step();
        start = 1'b1;
        step();
        hs4 = 0; hs0 = 0; busyn = 0; v0n = 0; d4at = 0; d0at = 0;
        for (int n = 1; n <= 110; n++) begin
            start = (n == 30);
            #1;
            if (v4 && tw_ready) hs4++;
            if (v0 && tw_ready) hs0++;
            if (busy4) busyn++;
            if (n <= 80 && v0) v0n++;
            if (done4 && d4at == 0) d4at = n;
            if (done0 && d0at == 0) d0at = n;
            if (n == 1) begin
                chk("first_valid", v4, 1);
                chk("first_item",  {st4, ix4}, 0);
                chk("first_tw",    tw4, 16'hA500);
            end
            if (n >= 41 && n <= 56) chk("s2_rom_sweep", tw4, 16'hA503 + ((n - 41) % 4));
            if (n == 46) begin
                chk("s2b5_item", {st4, ix4}, {3'd2, 4'd5});
                chk("s2b5_top",  top4, 9);
                chk("s2b5_bot",  bot4, 13);
            end
            if (n == 96) chk("final_last", {sl4, fl4, st4, ix4}, {2'b11, 3'd4, 4'd15});
            if (n == 97) chk("done_busy_low", busy4, 0);
            @(posedge clk); #1;
        end
        chk("g4_handshakes", hs4, 80);
        chk("g4_done_cycle", d4at, 97);
        chk("g4_busy_cycles", busyn, 96);
        chk("g0_handshakes", hs0, 80);
        chk("g0_no_bubble",  v0n, 80);
        chk("g0_done_cycle", d0at, 81);

        // Frame 2: stall 3 cycles at stage 3 bf 6, then 7 more during stage 4
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        hs4 = 0; d4at = 0;
        for (int n = 1; n <= 130; n++) begin
            tw_ready = !((n >= 67 && n <= 69) || (n >= 90 && n <= 96));
            #1;
            if (v4 && tw_ready) hs4++;
            if (done4 && d4at == 0) d4at = n;
            if (n >= 67 && n <= 69) begin
                chk("stall_item", {st4, ix4}, {3'd3, 4'd6});
                chk("stall_rom",  ra4, 13);
                chk("stall_tw",   tw4, 16'hA50D);
                chk("stall_addr", {top4, bot4}, {5'd6, 5'd14});
                chk("stall_valid", v4, 1);
            end
            if (n == 70) begin
                chk("post_stall_item", ix4, 6);
                chk("post_stall_rom",  ra4, 14);
            end
            if (n == 71) begin
                chk("next_item", ix4, 7);
                chk("next_tw",   tw4, 16'hA50E);
            end
            @(posedge clk); #1;
        end
        tw_ready = 1'b1;
        chk("stall_handshakes", hs4, 80);
        chk("stall_done_cycle", d4at, 107);
`ifdef TWSEQ_STALL_CNT_EN
        chk("stall_cnt_g4", sc4, 10);
        chk("stall_cnt_g0", sc0, 3);
`endif

        // Frame 3: reset at stage 1 bf 8, then restart
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (28) step();
        #1;
        chk("pre_rst_item", {st4, ix4}, {3'd1, 4'd8});
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_outs", {busy4, done4, v4, sl4, fl4, st4, ix4}, 0);
        chk("abort_addr", {ra4, top4, bot4}, 0);
`ifdef TWSEQ_STALL_CNT_EN
        chk("abort_stall_cnt", sc4, 0);
`endif
        dcnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (done4 || done0) dcnt++;
            step();
        end
        chk("abort_no_done", dcnt, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("restart_item", {v4, st4, ix4}, {1'b1, 3'd0, 4'd0});
        chk("restart_tw",   tw4, 16'hA500);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
